// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer
//   Front-end controller for the bank of per-regex DFA match engines. Maps a
//   16-bit flow key to one of 64 stream slots and walks the shared engine bus
//   through restore -> character stream -> commit for each packet.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   pkt_vld/pkt_rdy                 beat handshake (see below)
//   pkt_data/pkt_sop/pkt_eop        payload byte and packet delimiters
//   pkt_flow                        flow key, sampled on sop beats only
//   cfg_wr/cfg_slot/cfg_mask        per-slot engine enable mask write
//   load_state/new_stream_id        one-cycle restore pulse, fresh-slot flag
//   stream_id/enable                current slot and its mask, held load..eop
//   char_in/char_in_vld             byte stream to the engines
//   eop                             one-cycle commit pulse
//   busy                            FSM not idle
//   pkt_count/new_count/drop_count  statistics
//   dbg_state                       current FSM state encoding
//
// Handshake: a beat transfers on a rising clock edge where pkt_vld && pkt_rdy;
// pkt_rdy never depends on anything but state, pkt_vld and pkt_sop, and the
// source must hold the beat stable until it transfers.
module dpi_stream_sequencer #(
  parameter int                 NUM_ENG      = 16,
  parameter int                 PRIME_CYCLES = 2,
  parameter int                 DRAIN_CYCLES = 4,
  parameter logic [NUM_ENG-1:0] DEFAULT_MASK = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_vld,
  output logic               pkt_rdy,
  input  logic [7:0]         pkt_data,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [15:0]        pkt_flow,
  input  logic               cfg_wr,
  input  logic [5:0]         cfg_slot,
  input  logic [NUM_ENG-1:0] cfg_mask,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [5:0]         stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_ENG-1:0] enable,
  output logic               busy,
  output logic [31:0]        pkt_count,
  output logic [31:0]        new_count,
  output logic [15:0]        drop_count,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_LOAD, S_PRIME, S_STREAM, S_DRAIN, S_COMMIT
  } state_e;

  // The first accepted beat shows up on char_in one cycle after acceptance,
  // so LOAD plus (PRIME_CYCLES-1) PRIME cycles give PRIME_CYCLES idle engine
  // cycles before the first char_in_vld.
  localparam logic [7:0] PRIME_LAST = 8'(PRIME_CYCLES - 2);
  // DRAIN is entered on the cycle of the final char_in_vld and then waits
  // DRAIN_CYCLES more cycles before COMMIT.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rdy_c;

  logic [15:0]        flow_q;
  logic [15:0]        key_q  [64];
  logic [NUM_ENG-1:0] mask_q [64];
  logic [63:0]        valid_q;
  logic [5:0]         ptr_q;
  logic [5:0]         slot_q;
  logic               hit_new_q;
  logic [NUM_ENG-1:0] enable_q;
  logic [7:0]         char_q;
  logic               char_vld_q;
  logic [31:0]        pkt_cnt_q, new_cnt_q;
  logic [15:0]        drop_cnt_q;

  logic               hit;
  logic [5:0]         hit_idx;
  logic               alloc;

  // Keys are unique on write, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (valid_q[i] && key_q[i] == flow_q) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
  end

  assign alloc = (state_q == S_LOOKUP) && !hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stray non-sop beats are swallowed; a sop beat is left waiting.
        rdy_c = pkt_vld && !pkt_sop;
        if (pkt_vld && pkt_sop) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_PRIME;
        cnt_d   = '0;
      end
      S_PRIME: begin
        if (cnt_q == PRIME_LAST) state_d = S_STREAM;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      S_STREAM: begin
        rdy_c = 1'b1;
        if (pkt_vld && pkt_eop) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = S_COMMIT;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flow table, allocation pointer and enable masks. A cfg write to the slot
  // being allocated in the same cycle overrides the default mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < 64; i++) begin
        key_q[i]  <= '0;
        mask_q[i] <= DEFAULT_MASK;
      end
    end else begin
      if (alloc) begin
        valid_q[ptr_q] <= 1'b1;
        key_q[ptr_q]   <= flow_q;
        ptr_q          <= ptr_q + 6'd1;
      end
      for (int i = 0; i < 64; i++) begin
        if (cfg_wr && cfg_slot == 6'(i))  mask_q[i] <= cfg_mask;
        else if (alloc && ptr_q == 6'(i)) mask_q[i] <= DEFAULT_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flow_q     <= '0;
      slot_q     <= '0;
      hit_new_q  <= 1'b0;
      enable_q   <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      pkt_cnt_q  <= '0;
      new_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && pkt_vld && pkt_sop) flow_q <= pkt_flow;
      if (state_q == S_LOOKUP) begin
        slot_q    <= hit ? hit_idx : ptr_q;
        hit_new_q <= !hit;
      end
      if (alloc) new_cnt_q <= new_cnt_q + 32'd1;
      if (state_q == S_LOAD) enable_q <= mask_q[slot_q];
      char_vld_q <= (state_q == S_STREAM) && pkt_vld;
      if (state_q == S_STREAM && pkt_vld) char_q <= pkt_data;
      if (state_q == S_COMMIT) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (state_q == S_IDLE && pkt_vld && !pkt_sop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // pkt_rdy is forced low while reset is held so every output reads zero.
  assign pkt_rdy       = rdy_c && rst_n;
  assign load_state    = (state_q == S_LOAD);
  assign new_stream_id = (state_q == S_LOAD) && hit_new_q;
  assign stream_id     = slot_q;
  // In LOAD the mask is read straight from the table; afterwards it is held.
  assign enable        = (state_q == S_LOAD) ? mask_q[slot_q] : enable_q;
  assign char_in       = char_q;
  assign char_in_vld   = char_vld_q;
  assign eop           = (state_q == S_COMMIT);
  assign busy          = (state_q != S_IDLE);
  assign pkt_count     = pkt_cnt_q;
  assign new_count     = new_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
module tb_dpi_stream_sequencer;

  localparam int PRIME = 2;
  localparam int DRAIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        pkt_vld = 0, pkt_sop = 0, pkt_eop = 0, cfg_wr = 0;
  logic [7:0]  pkt_data = 0;
  logic [15:0] pkt_flow = 0, cfg_mask = 0;
  logic [5:0]  cfg_slot = 0;
  logic        pkt_rdy, load_state, new_stream_id, char_in_vld, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] enable, drop_count;
  logic [31:0] pkt_count, new_count;
  logic [2:0]  dbg_state;

  dpi_stream_sequencer #(.NUM_ENG(16), .PRIME_CYCLES(PRIME), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .pkt_data(pkt_data), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_flow(pkt_flow),
    .cfg_wr(cfg_wr), .cfg_slot(cfg_slot), .cfg_mask(cfg_mask),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .enable(enable),
    .busy(busy), .pkt_count(pkt_count), .new_count(new_count),
    .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [5:0] sid; logic nw; logic [15:0] en; } ev_t;
  typedef struct { int cyc; logic [7:0] d; } ch_t;
  ev_t load_q[$];
  ev_t eop_q[$];
  ch_t char_q[$];

  // Observations recorded for the hand-computed literal checks.
  int          last_load_cyc, last_eop_cyc, last_c0;
  logic [5:0]  last_load_sid;
  logic        last_load_new;
  logic [15:0] last_load_en, last_eop_en;
  int          char_log[$];

  // Behavioural model: flow table as plain arrays, timeline by arithmetic.
  logic [15:0] m_key [64];
  bit          m_val [64];
  logic [15:0] m_mask[64];
  int          m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_val[i]  = 0;
      m_key[i]  = 0;
      m_mask[i] = 16'hFFFF;
    end
    m_ptr = 0;
  endtask

  // Compare process: every cycle, each pulse output must match the timeline.
  always @(negedge clk) begin
    bit exp_l, exp_c, exp_e;
    if (!rst_n) begin
      load_q.delete();
      char_q.delete();
      eop_q.delete();
    end else begin
      while (load_q.size() > 0 && load_q[0].cyc < cyc) void'(load_q.pop_front());
      while (char_q.size() > 0 && char_q[0].cyc < cyc) void'(char_q.pop_front());
      while (eop_q.size()  > 0 && eop_q[0].cyc  < cyc) void'(eop_q.pop_front());
      exp_l = load_q.size() > 0 && load_q[0].cyc == cyc;
      exp_c = char_q.size() > 0 && char_q[0].cyc == cyc;
      exp_e = eop_q.size()  > 0 && eop_q[0].cyc  == cyc;
      chk("load_state", {31'd0, load_state}, {31'd0, exp_l});
      if (exp_l) begin
        chk("load_stream_id", {26'd0, stream_id}, {26'd0, load_q[0].sid});
        chk("load_new_stream_id", {31'd0, new_stream_id}, {31'd0, load_q[0].nw});
        chk("load_enable", {16'd0, enable}, {16'd0, load_q[0].en});
        void'(load_q.pop_front());
      end
      chk("char_in_vld", {31'd0, char_in_vld}, {31'd0, exp_c});
      if (exp_c) begin
        chk("char_in", {24'd0, char_in}, {24'd0, char_q[0].d});
        void'(char_q.pop_front());
      end
      chk("eop", {31'd0, eop}, {31'd0, exp_e});
      if (exp_e) begin
        chk("eop_stream_id", {26'd0, stream_id}, {26'd0, eop_q[0].sid});
        chk("eop_enable", {16'd0, enable}, {16'd0, eop_q[0].en});
        void'(eop_q.pop_front());
      end
      if (load_state) begin
        last_load_cyc = cyc; last_load_sid = stream_id;
        last_load_new = new_stream_id; last_load_en = enable;
      end
      if (char_in_vld) char_log.push_back(cyc);
      if (eop) begin
        last_eop_cyc = cyc; last_eop_en = enable;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Sends one packet of n back-to-back beats. Optionally writes cfg_mask to
  // the slot in the LOOKUP cycle. Aborts quietly if reset is asserted.
  task automatic send_pkt(input logic [15:0] flow, input int n,
                          input bit cfg_lk, input logic [15:0] cfg_m);
    int slot; bit nw; int c0; int b; bit acc; bit done;
    logic [7:0] d[$];
    ev_t e; ch_t c;
    wait_idle();
    @(posedge clk); #1;
    c0 = cyc; last_c0 = c0;
    slot = -1;
    for (int i = 0; i < 64; i++) if (m_val[i] && m_key[i] == flow) slot = i;
    if (slot < 0) begin
      slot = m_ptr; m_key[slot] = flow; m_val[slot] = 1; m_mask[slot] = 16'hFFFF;
      m_ptr = (m_ptr + 1) % 64; nw = 1;
    end else nw = 0;
    if (cfg_lk) m_mask[slot] = cfg_m;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
    e.cyc = c0 + 2; e.sid = 6'(slot); e.nw = nw; e.en = m_mask[slot];
    load_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      c.cyc = c0 + 3 + PRIME + i; c.d = d[i];
      char_q.push_back(c);
    end
    e.cyc = c0 + 3 + PRIME + n + DRAIN;
    eop_q.push_back(e);
    pkt_vld = 1; pkt_sop = 1; pkt_flow = flow; pkt_data = d[0]; pkt_eop = (n == 1);
    b = 0; done = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!rst_n) begin done = 1; break; end
      acc = pkt_vld && pkt_rdy;
      @(posedge clk); #1;
      if (cfg_lk) begin
        cfg_wr = (cyc == c0 + 1); cfg_slot = 6'(slot); cfg_mask = cfg_m;
      end
      if (acc) begin
        b++;
        if (b == n) begin done = 1; break; end
        pkt_sop = 0; pkt_data = d[b]; pkt_eop = (b == n - 1);
      end
    end
    pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
    if (cfg_lk) cfg_wr = 0;
    if (!done) chk("send_pkt_timeout", 32'd1, 32'd0);
  endtask

  task automatic cfg_write(input logic [5:0] slot, input logic [15:0] m);
    @(posedge clk); #1;
    cfg_wr = 1; cfg_slot = slot; cfg_mask = m;
    m_mask[slot] = m;
    @(posedge clk); #1;
    cfg_wr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_rdy"}, {31'd0, pkt_rdy}, 32'd0);
    chk({tag, "_pulses"}, {29'd0, load_state, char_in_vld, eop}, 32'd0);
    chk({tag, "_ids"}, {22'd0, new_stream_id, busy, char_in}, 32'd0);
    chk({tag, "_stream_enable"}, {10'd0, stream_id, enable}, 32'd0);
    chk({tag, "_pkt_count"}, pkt_count, 32'd0);
    chk({tag, "_new_count"}, new_count, 32'd0);
    chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    model_reset();
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // First packet: hand-computed timeline relative to the sop cycle.
    char_log.delete();
    send_pkt(16'h1234, 3, 0, 0);
    wait_idle();
    chk("t1_load_offset", 32'(last_load_cyc - last_c0), 32'd2);
    chk("t1_load_new", {31'd0, last_load_new}, 32'd1);
    chk("t1_load_sid", {26'd0, last_load_sid}, 32'd0);
    chk("t1_char_count", 32'(char_log.size()), 32'd3);
    if (char_log.size() == 3) begin
      chk("t1_char0", 32'(char_log[0] - last_c0), 32'd5);
      chk("t1_char2", 32'(char_log[2] - last_c0), 32'd7);
    end
    chk("t1_eop_offset", 32'(last_eop_cyc - last_c0), 32'd12);
    chk("t1_pkt_count", pkt_count, 32'd1);
    chk("t1_new_count", new_count, 32'd1);

    // Re-visit and a new flow.
    send_pkt(16'h1234, 2, 0, 0);
    wait_idle();
    chk("t2_hit_new", {31'd0, last_load_new}, 32'd0);
    chk("t2_hit_sid", {26'd0, last_load_sid}, 32'd0);
    chk("t2_new_count", new_count, 32'd1);
    send_pkt(16'h5678, 2, 0, 0);
    wait_idle();
    chk("t2_miss_sid", {26'd0, last_load_sid}, 32'd1);
    chk("t2_miss_new", {31'd0, last_load_new}, 32'd1);

    // Mid-packet mask write affects only the next packet.
    fork
      send_pkt(16'h1234, 4, 0, 0);
      begin repeat (6) @(posedge clk); cfg_write(6'd0, 16'h0005); end
    join
    wait_idle();
    chk("t3_eop_enable_old", {16'd0, last_eop_en}, 32'h0000FFFF);
    send_pkt(16'h1234, 2, 0, 0);
    wait_idle();
    chk("t3_load_enable_new", {16'd0, last_load_en}, 32'h00000005);

    // Two stray beats in IDLE.
    @(posedge clk); #1;
    pkt_vld = 1; pkt_sop = 0; pkt_data = 8'hAA;
    @(negedge clk) chk("t4_stray_rdy0", {31'd0, pkt_rdy}, 32'd1);
    @(posedge clk); #1 pkt_data = 8'hBB;
    @(negedge clk) chk("t4_stray_rdy1", {31'd0, pkt_rdy}, 32'd1);
    @(posedge clk); #1 pkt_vld = 0;
    repeat (3) @(posedge clk);
    #1 chk("t4_drop_count", {16'd0, drop_count}, 32'd2);

    // Single-beat packet.
    char_log.delete();
    send_pkt(16'h9ABC, 1, 0, 0);
    wait_idle();
    chk("t5_sid", {26'd0, last_load_sid}, 32'd2);
    chk("t5_char_count", 32'(char_log.size()), 32'd1);
    if (char_log.size() == 1)
      chk("t5_eop_gap", 32'(last_eop_cyc - char_log[0]), 32'(DRAIN + 1));

    // cfg write in the allocating LOOKUP cycle wins over the default.
    send_pkt(16'hBEEF, 2, 1, 16'h00A0);
    wait_idle();
    chk("t6_sid", {26'd0, last_load_sid}, 32'd3);
    chk("t6_enable", {16'd0, last_load_en}, 32'h000000A0);
    chk("t6_pkt_count", pkt_count, 32'd7);

    // Pointer wrap and eviction.
    do_reset();
    for (int i = 0; i < 65; i++) send_pkt(16'h1000 + 16'(i), 1, 0, 0);
    wait_idle();
    chk("t7_wrap_sid", {26'd0, last_load_sid}, 32'd0);
    send_pkt(16'h1000, 1, 0, 0);
    wait_idle();
    chk("t7_evicted_sid", {26'd0, last_load_sid}, 32'd1);
    chk("t7_evicted_new", {31'd0, last_load_new}, 32'd1);
    chk("t7_new_count", new_count, 32'd66);

    // Reset in the middle of STREAM with pkt_vld held.
    do_reset();
    fork
      send_pkt(16'h1234, 10, 0, 0);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (char_in_vld) break;
        end
        @(posedge clk); #1 rst_n = 0;
        model_reset();
        #2 chk_all_zero("t8_midreset");
      end
    join
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send_pkt(16'h1234, 2, 0, 0);
    wait_idle();
    chk("t8_new", {31'd0, last_load_new}, 32'd1);
    chk("t8_sid", {26'd0, last_load_sid}, 32'd0);
    chk("t8_pkt_count", pkt_count, 32'd1);

    repeat (4) @(posedge clk);
    chk("queues_empty", 32'(load_q.size() + char_q.size() + eop_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
